// File: rtl/dphy_lane_rx_if.sv
// dphy_lane_rx_if: lane-side signals of the D-PHY data-lane receiver.
//   Inputs to the receiver:  lp_rxp_i, lp_rxn_i (raw LP comparators),
//                            serdes_data_i (HS byte, bit 0 earliest),
//                            lane_invert_i (static p/n swap + HS invert).
//   Outputs from receiver:   hs_term_o, hs_data_o, hs_valid_o, hs_sot_o,
//                            hs_eot_o, lp_data_o, lp_valid_o, lp_active_o,
//                            err_o, idle_o.
// master = line/PHY side driving the lane, slave = the receiver.
interface dphy_lane_rx_if;
    logic       lp_rxp_i;
    logic       lp_rxn_i;
    logic [7:0] serdes_data_i;
    logic       lane_invert_i;
    logic       hs_term_o;
    logic [7:0] hs_data_o;
    logic       hs_valid_o;
    logic       hs_sot_o;
    logic       hs_eot_o;
    logic [7:0] lp_data_o;
    logic       lp_valid_o;
    logic       lp_active_o;
    logic       err_o;
    logic       idle_o;

    modport master (
        output lp_rxp_i, lp_rxn_i, serdes_data_i, lane_invert_i,
        input  hs_term_o, hs_data_o, hs_valid_o, hs_sot_o, hs_eot_o,
        input  lp_data_o, lp_valid_o, lp_active_o, err_o, idle_o
    );

    modport slave (
        input  lp_rxp_i, lp_rxn_i, serdes_data_i, lane_invert_i,
        output hs_term_o, hs_data_o, hs_valid_o, hs_sot_o, hs_eot_o,
        output lp_data_o, lp_valid_o, lp_active_o, err_o, idle_o
    );
endinterface

// File: rtl/dphy_lane_rx.sv
// dphy_lane_rx: receive side of one DSI D-PHY data lane.
//   Tracks the filtered LP line state, separates HS bursts (aligned to the
//   0xB8 sync word) from LP escape transfers (spaced-one-hot bits -> bytes).
// Ports:
//   clk_i  byte clock (one deserialized byte per clock)
//   rst_i  asynchronous active-high reset
//   lane   dphy_lane_rx_if.slave (LP pins, HS byte, invert in; HS/LP data,
//          strobes, term enable, error and idle out)
module dphy_lane_rx #(
    parameter int unsigned G_FILTER       = 4,
    parameter int unsigned G_SYNC_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dphy_lane_rx_if.slave    lane
);

    localparam int unsigned FILT_W = $clog2(G_FILTER + 1);
    localparam int unsigned SYNC_W = $clog2(G_SYNC_TIMEOUT + 1);
    localparam logic [7:0]  SYNC_WORD = 8'hB8;

    typedef enum logic [3:0] {
        ST_STOP, ST_HS_RQST, ST_HS_SYNC, ST_HS_DATA,
        ST_ESC_RQST, ST_ESC_BRIDGE, ST_ESC_ACK, ST_ESC_SPACE, ST_ESC_MARK,
        ST_WAIT11
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync1_q, sync1_d, sync2_q;
    logic [1:0]          cand_q, cand_d, l_q, l_d;
    logic [FILT_W-1:0]   fcnt_q, fcnt_d;
    logic [7:0]          prev_q, prev_d;
    logic [2:0]          k_q, k_d;
    logic [SYNC_W-1:0]   scnt_q, scnt_d;
    logic                bit_q, bit_d;
    logic [2:0]          bcnt_q, bcnt_d;
    logic [7:0]          shreg_q, shreg_d;

    logic                hs_term_q, hs_term_d;
    logic [7:0]          hs_data_q, hs_data_d;
    logic                hs_valid_q, hs_valid_d;
    logic                hs_sot_q, hs_sot_d;
    logic                hs_eot_q, hs_eot_d;
    logic [7:0]          lp_data_q, lp_data_d;
    logic                lp_valid_q, lp_valid_d;
    logic                lp_active_q, lp_active_d;
    logic                err_q, err_d;
    logic                idle_q, idle_d;

    logic                l_chg;
    logic [7:0]          din;
    logic [14:0]         window;
    logic                match;
    logic [2:0]          k_hit;
    logic [7:0]          aligned;

    // Pin swap ahead of the synchronizer so everything downstream sees {p,n}.
    always_comb begin
        sync1_d = lane.lane_invert_i ? {lane.lp_rxn_i, lane.lp_rxp_i}
                                     : {lane.lp_rxp_i, lane.lp_rxn_i};
    end

    // Glitch filter: accept a new synced state after G_FILTER equal clocks.
    always_comb begin
        l_d    = l_q;
        cand_d = cand_q;
        fcnt_d = fcnt_q;
        if (sync2_q == l_q) begin
            cand_d = l_q;
            fcnt_d = '0;
        end else begin
            if (sync2_q == cand_q) begin
                fcnt_d = fcnt_q + FILT_W'(1);
            end else begin
                cand_d = sync2_q;
                fcnt_d = FILT_W'(1);
            end
            if (fcnt_d == FILT_W'(G_FILTER)) begin
                l_d    = sync2_q;
                fcnt_d = '0;
            end
        end
        l_chg = (l_d != l_q);
    end

    // HS alignment window; bit 15 is never needed since k tops out at 7.
    always_comb begin
        din     = lane.serdes_data_i ^ {8{lane.lane_invert_i}};
        prev_d  = din;
        window  = {din[6:0], prev_q};
        match   = 1'b0;
        k_hit   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!match && (window[i +: 8] == SYNC_WORD)) begin
                match = 1'b1;
                k_hit = 3'(i);
            end
        end
        aligned = window[k_q +: 8];
    end

    // Lane FSM: reacts on the edge the filter accepts a new L.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        scnt_d     = scnt_q;
        bit_d      = bit_q;
        bcnt_d     = bcnt_q;
        shreg_d    = shreg_q;
        hs_data_d  = hs_data_q;
        lp_data_d  = lp_data_q;
        hs_valid_d = 1'b0;
        hs_sot_d   = 1'b0;
        hs_eot_d   = 1'b0;
        lp_valid_d = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            ST_STOP: begin
                if (l_chg) begin
                    unique case (l_d)
                        2'b01:   state_d = ST_HS_RQST;
                        2'b10:   state_d = ST_ESC_RQST;
                        default: begin err_d = 1'b1; state_d = ST_WAIT11; end
                    endcase
                end
            end
            ST_HS_RQST: begin
                if (l_chg) begin
                    unique case (l_d)
                        2'b00:   begin state_d = ST_HS_SYNC; scnt_d = '0; end
                        2'b11:   state_d = ST_STOP;
                        default: begin err_d = 1'b1; state_d = ST_WAIT11; end
                    endcase
                end
            end
            ST_HS_SYNC: begin
                scnt_d = scnt_q + SYNC_W'(1);
                if (l_chg && (l_d == 2'b11)) begin
                    err_d   = 1'b1;
                    state_d = ST_STOP;
                end else if (match) begin
                    k_d      = k_hit;
                    hs_sot_d = 1'b1;
                    state_d  = ST_HS_DATA;
                end else if (scnt_q == SYNC_W'(G_SYNC_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT11;
                end
            end
            ST_HS_DATA: begin
                if (l_chg && (l_d == 2'b11)) begin
                    hs_eot_d = 1'b1;
                    state_d  = ST_STOP;
                end else begin
                    hs_valid_d = 1'b1;
                    hs_data_d  = aligned;
                end
            end
            ST_ESC_RQST: begin
                if (l_chg) begin
                    unique case (l_d)
                        2'b00:   state_d = ST_ESC_BRIDGE;
                        2'b11:   state_d = ST_STOP;
                        default: begin err_d = 1'b1; state_d = ST_WAIT11; end
                    endcase
                end
            end
            ST_ESC_BRIDGE: begin
                if (l_chg) begin
                    if (l_d == 2'b01) begin
                        state_d = ST_ESC_ACK;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT11;
                    end
                end
            end
            ST_ESC_ACK: begin
                if (l_chg) begin
                    if (l_d == 2'b00) begin
                        bcnt_d  = 3'd0;
                        state_d = ST_ESC_SPACE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT11;
                    end
                end
            end
            ST_ESC_SPACE: begin
                if (l_chg) begin
                    unique case (l_d)
                        2'b10:   begin bit_d = 1'b1; state_d = ST_ESC_MARK; end
                        2'b01:   begin bit_d = 1'b0; state_d = ST_ESC_MARK; end
                        default: begin err_d = 1'b1; state_d = ST_WAIT11; end
                    endcase
                end
            end
            ST_ESC_MARK: begin
                if (l_chg) begin
                    unique case (l_d)
                        2'b00: begin
                            shreg_d = {shreg_q[6:0], bit_q};
                            if (bcnt_q == 3'd7) begin
                                lp_valid_d = 1'b1;
                                lp_data_d  = shreg_d;
                                bcnt_d     = 3'd0;
                            end else begin
                                bcnt_d = bcnt_q + 3'd1;
                            end
                            state_d = ST_ESC_SPACE;
                        end
                        2'b11: begin
                            // Mark-1 straight to stop is the exit; a partial byte is dropped.
                            if (bit_q) begin
                                err_d   = (bcnt_q != 3'd0);
                                state_d = ST_STOP;
                            end else begin
                                err_d   = 1'b1;
                                state_d = ST_WAIT11;
                            end
                        end
                        default: begin err_d = 1'b1; state_d = ST_WAIT11; end
                    endcase
                end
            end
            ST_WAIT11: begin
                if (l_d == 2'b11) state_d = ST_STOP;
            end
            default: state_d = ST_STOP;
        endcase

        hs_term_d   = (state_d == ST_HS_SYNC) || (state_d == ST_HS_DATA);
        idle_d      = (state_d == ST_STOP);
        lp_active_d = (state_d == ST_ESC_ACK) || (state_d == ST_ESC_SPACE) ||
                      (state_d == ST_ESC_MARK);
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_STOP;
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            cand_q      <= 2'b11;
            l_q         <= 2'b11;
            fcnt_q      <= '0;
            prev_q      <= '0;
            k_q         <= '0;
            scnt_q      <= '0;
            bit_q       <= 1'b0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            hs_term_q   <= 1'b0;
            hs_data_q   <= '0;
            hs_valid_q  <= 1'b0;
            hs_sot_q    <= 1'b0;
            hs_eot_q    <= 1'b0;
            lp_data_q   <= '0;
            lp_valid_q  <= 1'b0;
            lp_active_q <= 1'b0;
            err_q       <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync1_q;
            cand_q      <= cand_d;
            l_q         <= l_d;
            fcnt_q      <= fcnt_d;
            prev_q      <= prev_d;
            k_q         <= k_d;
            scnt_q      <= scnt_d;
            bit_q       <= bit_d;
            bcnt_q      <= bcnt_d;
            shreg_q     <= shreg_d;
            hs_term_q   <= hs_term_d;
            hs_data_q   <= hs_data_d;
            hs_valid_q  <= hs_valid_d;
            hs_sot_q    <= hs_sot_d;
            hs_eot_q    <= hs_eot_d;
            lp_data_q   <= lp_data_d;
            lp_valid_q  <= lp_valid_d;
            lp_active_q <= lp_active_d;
            err_q       <= err_d;
            idle_q      <= idle_d;
        end
    end

    assign lane.hs_term_o   = hs_term_q;
    assign lane.hs_data_o   = hs_data_q;
    assign lane.hs_valid_o  = hs_valid_q;
    assign lane.hs_sot_o    = hs_sot_q;
    assign lane.hs_eot_o    = hs_eot_q;
    assign lane.lp_data_o   = lp_data_q;
    assign lane.lp_valid_o  = lp_valid_q;
    assign lane.lp_active_o = lp_active_q;
    assign lane.err_o       = err_q;
    assign lane.idle_o      = idle_q;

endmodule

// File: tb/tb_dphy_lane_rx.sv
// tb_dphy_lane_rx: directed bench for dphy_lane_rx with an output scoreboard.
module tb_dphy_lane_rx;
    localparam int unsigned G_FILTER       = 4;
    localparam int unsigned G_SYNC_TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dphy_lane_rx_if lane_if ();

    dphy_lane_rx #(
        .G_FILTER       (G_FILTER),
        .G_SYNC_TIMEOUT (G_SYNC_TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .lane  (lane_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ser_q  [$];
    logic [7:0] exp_hs [$];
    logic [7:0] exp_lp [$];
    logic       inv = 1'b0;

    int sot_cnt = 0, eot_cnt = 0, err_cnt = 0, lpv_cnt = 0;
    int hs_extra = 0, lp_unexp = 0, hs_run = 0;
    int sot_cyc = 0, eot_cyc = 0, err_cyc = 0, term_rise_cyc = 0;
    logic term_prev = 1'b0;
    logic [7:0] mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Output monitor: pops the scoreboard whenever the DUT delivers data.
    always @(negedge clk) begin
        if (!rst) begin
            if (lane_if.hs_sot_o) begin
                sot_cnt++;
                sot_cyc = cyc;
                hs_run  = 0;
            end
            if (lane_if.hs_valid_o) begin
                if (exp_hs.size() > 0) begin
                    if (hs_run == 0) check("hs_first_latency", 32'(cyc - sot_cyc), 32'd1);
                    mon_e = exp_hs.pop_front();
                    check("hs_data", 32'(lane_if.hs_data_o), 32'(mon_e));
                    hs_run++;
                end else begin
                    hs_extra++;
                end
            end
            if (lane_if.hs_eot_o) begin
                eot_cnt++;
                eot_cyc = cyc;
                check("eot_valid_low", 32'(lane_if.hs_valid_o), 32'd0);
                check("eot_term_low", 32'(lane_if.hs_term_o), 32'd0);
            end
            if (lane_if.lp_valid_o) begin
                lpv_cnt++;
                check("lp_active_at_valid", 32'(lane_if.lp_active_o), 32'd1);
                check("lp_hs_exclusive", 32'(lane_if.hs_valid_o), 32'd0);
                if (exp_lp.size() > 0) begin
                    mon_e = exp_lp.pop_front();
                    check("lp_data", 32'(lane_if.lp_data_o), 32'(mon_e));
                end else begin
                    lp_unexp++;
                end
            end
            if (lane_if.err_o) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (lane_if.hs_term_o && !term_prev) term_rise_cyc = cyc;
            term_prev = lane_if.hs_term_o;
        end
    end

    task automatic tick(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            b = (ser_q.size() > 0) ? ser_q.pop_front() : 8'h00;
            lane_if.serdes_data_i = inv ? ~b : b;
        end
    endtask

    task automatic set_lp(input logic [1:0] l);
        if (inv) begin
            lane_if.lp_rxp_i = l[0];
            lane_if.lp_rxn_i = l[1];
        end else begin
            lane_if.lp_rxp_i = l[1];
            lane_if.lp_rxn_i = l[0];
        end
    endtask

    task automatic hs_burst(input int shift);
        int s0, e0, r0, c0;
        logic [63:0] st;
        s0 = sot_cnt; e0 = eot_cnt; r0 = err_cnt;
        set_lp(2'b01); tick(8);
        set_lp(2'b00); tick(8);
        check("hs_term_in_sync", 32'(lane_if.hs_term_o), 32'd1);
        st = 64'h0000_0033_2211_B800_00 >> 8;
        st = 64'h0000_0033_2211_B800 << shift;
        for (int i = 0; i < 8; i++) ser_q.push_back(st[8*i +: 8]);
        exp_hs.push_back(8'h11);
        exp_hs.push_back(8'h22);
        exp_hs.push_back(8'h33);
        tick(14);
        check("hs_sot_count", 32'(sot_cnt - s0), 32'd1);
        check("hs_bytes_pending", 32'(exp_hs.size()), 32'd0);
        check("hs_valid_hold", 32'(lane_if.hs_valid_o), 32'd1);
        c0 = cyc;
        set_lp(2'b11); tick(10);
        check("hs_eot_count", 32'(eot_cnt - e0), 32'd1);
        check("hs_eot_latency", 32'(eot_cyc - c0), 32'(G_FILTER + 2));
        check("hs_idle_after", 32'(lane_if.idle_o), 32'd1);
        check("hs_term_after", 32'(lane_if.hs_term_o), 32'd0);
        check("hs_no_err", 32'(err_cnt - r0), 32'd0);
    endtask

    task automatic esc_enter();
        set_lp(2'b10); tick(8);
        set_lp(2'b00); tick(8);
        set_lp(2'b01); tick(8);
        set_lp(2'b00); tick(8);
    endtask

    task automatic send_bit(input logic b);
        set_lp(b ? 2'b10 : 2'b01); tick(8);
        set_lp(2'b00); tick(8);
    endtask

    initial begin
        int r0, v0, s0;
        logic [7:0] byte_v;
        logic [4:0] part_v;

        lane_if.lane_invert_i = 1'b0;
        lane_if.serdes_data_i = 8'h00;
        set_lp(2'b11);
        rst = 1'b1;
        tick(3);
        check("rst_idle", 32'(lane_if.idle_o), 32'd1);
        check("rst_term", 32'(lane_if.hs_term_o), 32'd0);
        check("rst_hs_valid", 32'(lane_if.hs_valid_o), 32'd0);
        check("rst_err", 32'(lane_if.err_o), 32'd0);
        check("rst_lp_active", 32'(lane_if.lp_active_o), 32'd0);
        check("rst_lp_valid", 32'(lane_if.lp_valid_o), 32'd0);
        rst = 1'b0;
        tick(4);

        // HS burst, byte-aligned sync word
        hs_burst(0);
        // HS burst, sync word straddling bytes by 3 bits
        hs_burst(3);

        // Sync timeout
        r0 = err_cnt; s0 = sot_cnt;
        set_lp(2'b01); tick(8);
        set_lp(2'b00); tick(75);
        check("to_no_sot", 32'(sot_cnt - s0), 32'd0);
        check("to_err_count", 32'(err_cnt - r0), 32'd1);
        check("to_err_cycle", 32'(err_cyc - term_rise_cyc), 32'(G_SYNC_TIMEOUT));
        check("to_not_idle", 32'(lane_if.idle_o), 32'd0);
        set_lp(2'b11); tick(8);
        check("to_idle_after", 32'(lane_if.idle_o), 32'd1);

        // LPDT: A5 then 3C
        r0 = err_cnt; v0 = lpv_cnt;
        esc_enter();
        check("lpdt_active", 32'(lane_if.lp_active_o), 32'd1);
        exp_lp.push_back(8'hA5);
        exp_lp.push_back(8'h3C);
        byte_v = 8'hA5;
        for (int i = 7; i >= 0; i--) send_bit(byte_v[i]);
        byte_v = 8'h3C;
        for (int i = 7; i >= 0; i--) send_bit(byte_v[i]);
        set_lp(2'b10); tick(8);
        check("lpdt_active_end", 32'(lane_if.lp_active_o), 32'd1);
        set_lp(2'b11); tick(8);
        check("lpdt_valid_count", 32'(lpv_cnt - v0), 32'd2);
        check("lpdt_pending", 32'(exp_lp.size()), 32'd0);
        check("lpdt_no_err", 32'(err_cnt - r0), 32'd0);
        check("lpdt_idle", 32'(lane_if.idle_o), 32'd1);
        check("lpdt_inactive", 32'(lane_if.lp_active_o), 32'd0);

        // Partial byte exit after 5 bits
        r0 = err_cnt; v0 = lpv_cnt;
        esc_enter();
        part_v = 5'b10110;
        for (int i = 4; i >= 0; i--) send_bit(part_v[i]);
        set_lp(2'b10); tick(8);
        set_lp(2'b11); tick(8);
        check("part_err", 32'(err_cnt - r0), 32'd1);
        check("part_no_valid", 32'(lpv_cnt - v0), 32'd0);
        check("part_idle", 32'(lane_if.idle_o), 32'd1);

        // Two-clock glitch on lp_rxp_i is filtered out
        r0 = err_cnt;
        set_lp(2'b01); tick(2);
        set_lp(2'b11); tick(10);
        check("glitch_idle", 32'(lane_if.idle_o), 32'd1);
        check("glitch_no_err", 32'(err_cnt - r0), 32'd0);
        check("glitch_term", 32'(lane_if.hs_term_o), 32'd0);

        // Inverted lane: swapped pins and inverted HS data
        inv = 1'b1;
        lane_if.lane_invert_i = 1'b1;
        set_lp(2'b11); tick(4);
        hs_burst(0);
        inv = 1'b0;
        lane_if.lane_invert_i = 1'b0;
        set_lp(2'b11); tick(4);

        // Direct 11 -> 00 is a protocol error, then wait for 11
        r0 = err_cnt;
        set_lp(2'b00); tick(8);
        check("p00_err", 32'(err_cnt - r0), 32'd1);
        check("p00_wait11", 32'(lane_if.idle_o), 32'd0);
        set_lp(2'b11); tick(8);
        check("p00_idle_after", 32'(lane_if.idle_o), 32'd1);

        // Reset asserted mid-burst
        set_lp(2'b01); tick(8);
        set_lp(2'b00); tick(8);
        check("mrst_term_before", 32'(lane_if.hs_term_o), 32'd1);
        rst = 1'b1;
        #1;
        check("mrst_term", 32'(lane_if.hs_term_o), 32'd0);
        check("mrst_idle", 32'(lane_if.idle_o), 32'd1);
        check("mrst_hs_valid", 32'(lane_if.hs_valid_o), 32'd0);
        set_lp(2'b11); tick(3);
        rst = 1'b0;
        tick(4);
        check("mrst_idle_after", 32'(lane_if.idle_o), 32'd1);
        check("no_unexpected_lp", 32'(lp_unexp), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
